// File: rtl/interfaz_crono.sv
// Control FSM for the countdown-timer (crono): programming, arming, running and alarm.
// Drives CronoActivo (counter enable) and Ring (alarm indicator), both registered.
module interfaz_crono #(
    parameter int RING_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ProgramarCrono,
    input  logic InicioCrono,
    input  logic FinalizoCrono,
    output logic CronoActivo,
    output logic Ring
);

    localparam int CW = $clog2(RING_CYCLES + 1);
    localparam logic [CW-1:0] RING_LAST = CW'(RING_CYCLES - 1);

    typedef enum logic [1:0] {
        PROGRAM = 2'd0,
        READY   = 2'd1,
        RUN     = 2'd2,
        RING    = 2'd3
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] ringCnt;
    logic [CW-1:0] ringCntNext;

    always_comb begin
        stateNext = state;
        if (ProgramarCrono) begin
            stateNext = PROGRAM;
        end else begin
            unique case (state)
                PROGRAM: stateNext = InicioCrono ? RUN : READY;
                READY:   stateNext = InicioCrono ? RUN : READY;
                RUN: begin
                    // End of count wins over a simultaneous pause request
                    if (FinalizoCrono)     stateNext = RING;
                    else if (!InicioCrono) stateNext = READY;
                    else                   stateNext = RUN;
                end
                RING:    stateNext = (ringCnt == RING_LAST) ? READY : RING;
                default: stateNext = PROGRAM;
            endcase
        end
    end

    always_comb begin
        ringCntNext = '0;
        if (state == RING && stateNext == RING) begin
            ringCntNext = ringCnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PROGRAM;
            ringCnt     <= '0;
            CronoActivo <= 1'b0;
            Ring        <= 1'b0;
        end else begin
            state       <= stateNext;
            ringCnt     <= ringCntNext;
            CronoActivo <= (stateNext == RUN);
            Ring        <= (stateNext == RING);
        end
    end

endmodule

// File: tb/tb_interfaz_crono.sv
// Directed bench for interfaz_crono: table of vectors plus hand sequences
// for the alarm duration, abort and hold-over cases.
module tb_interfaz_crono;

    logic clk = 1'b0;
    logic reset;
    logic ProgramarCrono;
    logic InicioCrono;
    logic FinalizoCrono;
    logic CronoActivo;
    logic Ring;

    int checks = 0;
    int failures = 0;

    interfaz_crono #(.RING_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .ProgramarCrono(ProgramarCrono),
        .InicioCrono(InicioCrono),
        .FinalizoCrono(FinalizoCrono),
        .CronoActivo(CronoActivo),
        .Ring(Ring)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  rst;
        logic  prog;
        logic  ini;
        logic  fin;
        logic  expActivo;
        logic  expRing;
        string name;
    } vec_t;

    vec_t vecs[13];

    task automatic step(input logic rst, input logic prog, input logic ini,
                        input logic fin, input logic expActivo,
                        input logic expRing, input string name);
        @(negedge clk);
        reset = rst;
        ProgramarCrono = prog;
        InicioCrono = ini;
        FinalizoCrono = fin;
        @(posedge clk);
        #1;
        checks++;
        if (CronoActivo !== expActivo || Ring !== expRing) begin
            failures++;
            $display("FAIL %s: CronoActivo=%b Ring=%b, required CronoActivo=%b Ring=%b",
                     name, CronoActivo, Ring, expActivo, expRing);
        end
    endtask

    int ringHigh;

    initial begin
        reset = 1'b1;
        ProgramarCrono = 1'b0;
        InicioCrono = 1'b0;
        FinalizoCrono = 1'b0;

        //          rst   prog  ini   fin   act   ring
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_cyc1"};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_cyc2"};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "program_to_run"};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "run_pause"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "ready_resume"};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset_beats_fin"};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "program_to_ready"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ready_ignores_fin"};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ready_to_program"};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "program_holds"};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "program_ignores_fin"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "run_stays"};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "run_fin_to_ring"};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].prog, vecs[i].ini, vecs[i].fin,
                 vecs[i].expActivo, vecs[i].expRing, vecs[i].name);
        end

        // Alarm already high for one cycle; it must last exactly 8 in total
        ringHigh = 1;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "ring_holds");
            if (Ring === 1'b1) ringHigh++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ring_expires");
        checks++;
        if (ringHigh != 8) begin
            failures++;
            $display("FAIL ring_length: got %0d cycles, required 8", ringHigh);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ready_fin_held");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ready_idle");

        // Abort the alarm on its third cycle
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "ready_to_run");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "ring_cyc1");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "ring_cyc2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ring_cyc3");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ring_abort");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_to_ready");

        // Programming aborts a running count
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rearm_run");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "run_abort");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "run_again");

        // A fresh alarm after an abort starts its count from zero
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "ring2_entry");
        ringHigh = 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i < 7) ? 1'b1 : 1'b0,
                 "ring2_window");
            if (Ring === 1'b1) ringHigh++;
        end
        checks++;
        if (ringHigh != 8) begin
            failures++;
            $display("FAIL ring2_length: got %0d cycles, required 8", ringHigh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
